// File: rtl/cineraria_bootmem_pkg.sv
// Shared types and helpers for the boot RAM arbiter.
// Holds the grant-state enum, the port identifiers and the burst-counter width helper.
package cineraria_bootmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_st_t;

    localparam logic PORT_M0 = 1'b0;
    localparam logic PORT_M1 = 1'b1;

    // Width needed to hold burst counts 0..max_burst.
    function automatic int burst_w(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/cineraria_bootmem_rr_pick.sv
// Two-way round-robin picker with a burst cap.
// Owns the last-grant and burst-count registers; grants at most one requester per cycle.
module cineraria_bootmem_rr_pick
    import cineraria_bootmem_pkg::*;
#(
    parameter int MAX_BURST = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       hold_ok,
    output logic [1:0] gnt
);

    localparam int BW = burst_w(MAX_BURST);
    localparam logic [BW-1:0] CAP = BW'(MAX_BURST);

    logic          last_q, last_d;
    logic [BW-1:0] cnt_q, cnt_d;
    logic          win;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= PORT_M1;
            cnt_q  <= '0;
        end else begin
            last_q <= last_d;
            cnt_q  <= cnt_d;
        end
    end

    // hold_ok low suppresses every grant; the registers then hold.
    // A zero count means no burst is running yet, so the first tie switches ports.
    always_comb begin
        win    = PORT_M0;
        gnt    = 2'b00;
        last_d = last_q;
        cnt_d  = cnt_q;
        if (req == 2'b11) begin
            if ((cnt_q != '0) && (cnt_q < CAP)) begin
                win = last_q;
            end else begin
                win = ~last_q;
            end
        end else begin
            win = req[1];
        end
        if (hold_ok && (req != 2'b00)) begin
            gnt    = win ? 2'b10 : 2'b01;
            last_d = win;
            if (win != last_q) begin
                cnt_d = BW'(1);
            end else if (cnt_q < CAP) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cineraria_core_bootmem_arbiter.sv
// Shares the single-port boot RAM between m0 (CPU) and m1 (loader/debug), one access per clock.
// Optional m1 write protection is built when CINERARIA_BOOTMEM_WPROT_EN is defined.
module cineraria_core_bootmem_arbiter
    import cineraria_bootmem_pkg::*;
#(
    parameter int ADDR_W    = 14,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                reset_req,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic [DATA_W-1:0]   m0_writedata,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic [DATA_W-1:0]   m1_writedata,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,
`ifdef CINERARIA_BOOTMEM_WPROT_EN
    input  logic                wprot,
    output logic                m1_wrerr,
`endif
    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic                mem_clken,
    output logic                mem_reset_req,
    input  logic [DATA_W-1:0]   mem_readdata,
    output arb_st_t             dbg_state
);

    logic [1:0] req;
    logic [1:0] gnt;
    logic       hold_ok;
    logic       wr_sel;
    logic       rd_sel;
    logic       wp_block;
    logic       rd_q, rd_d;
    arb_st_t    state_q, state_d;

    // Valid/ready: a port's request (read|write) is accepted in the cycle its
    // waitrequest is low; read data follows exactly one cycle later with readdatavalid.
    assign req     = {m1_read | m1_write, m0_read | m0_write};
    assign hold_ok = ~reset_req & ~reset;

    cineraria_bootmem_rr_pick #(
        .MAX_BURST(MAX_BURST)
    ) u_pick (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .hold_ok(hold_ok),
        .gnt    (gnt)
    );

`ifdef CINERARIA_BOOTMEM_WPROT_EN
    logic wrerr_q;

    assign wp_block = gnt[PORT_M1] & m1_write & wprot;
    assign m1_wrerr = wrerr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrerr_q <= 1'b0;
        end else begin
            wrerr_q <= wp_block;
        end
    end
`else
    assign wp_block = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
        end
    end

    // Write wins when a master illegally raises read and write together.
    always_comb begin
        mem_address    = m0_address;
        mem_byteenable = m0_byteenable;
        mem_writedata  = m0_writedata;
        wr_sel         = m0_write;
        rd_sel         = m0_read & ~m0_write;
        if (gnt[PORT_M1]) begin
            mem_address    = m1_address;
            mem_byteenable = m1_byteenable;
            mem_writedata  = m1_writedata;
            wr_sel         = m1_write;
            rd_sel         = m1_read & ~m1_write;
        end
        mem_chipselect = |gnt;
        mem_write      = (|gnt) & wr_sel & ~wp_block;
        rd_d           = (|gnt) & rd_sel;
        state_d        = IDLE;
        if (gnt[PORT_M0]) begin
            state_d = GNT0;
        end else if (gnt[PORT_M1]) begin
            state_d = GNT1;
        end
    end

    assign m0_waitrequest   = ~gnt[PORT_M0];
    assign m1_waitrequest   = ~gnt[PORT_M1];
    assign m0_readdata      = mem_readdata;
    assign m1_readdata      = mem_readdata;
    assign m0_readdatavalid = rd_q & (state_q == GNT0);
    assign m1_readdatavalid = rd_q & (state_q == GNT1);
    assign mem_clken        = 1'b1;
    assign mem_reset_req    = reset_req;
    assign dbg_state        = state_q;

endmodule

// File: tb/tb_cineraria_core_bootmem_arbiter.sv
// Bench for the boot RAM arbiter: behavioural RAM, directed drivers, and a
// response monitor that pops expected {port, data} entries from a queue.
module tb_cineraria_core_bootmem_arbiter;
  import cineraria_bootmem_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        reset_req = 1'b0;
  logic [13:0] m0_address = '0, m1_address = '0;
  logic        m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
  logic [3:0]  m0_byteenable = 4'hf, m1_byteenable = 4'hf;
  logic [31:0] m0_writedata = '0, m1_writedata = '0;
  logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic [31:0] m0_readdata, m1_readdata;
  logic [13:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_writedata, mem_readdata;
  logic        mem_chipselect, mem_write, mem_clken, mem_reset_req;
  arb_st_t     dbg_state;
`ifdef CINERARIA_BOOTMEM_WPROT_EN
  logic        wprot = 1'b0;
  logic        m1_wrerr;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [32:0] exp_q[$];

  cineraria_core_bootmem_arbiter #(.ADDR_W(14), .DATA_W(32), .MAX_BURST(8)) dut (
    .clk(clk), .reset(reset), .reset_req(reset_req),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
`ifdef CINERARIA_BOOTMEM_WPROT_EN
    .wprot(wprot), .m1_wrerr(m1_wrerr),
`endif
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_writedata(mem_writedata), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_clken(mem_clken), .mem_reset_req(mem_reset_req),
    .mem_readdata(mem_readdata), .dbg_state(dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Behavioural boot RAM: address registered when clocked, read data unregistered.
  logic [31:0] ram [0:16383];
  logic [13:0] ram_addr_q = '0;
  initial begin
    for (int i = 0; i < 16384; i++) ram[i] = 32'hA500_0000 | 32'(i);
  end
  always @(posedge clk) begin
    if (mem_clken && !mem_reset_req && mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end
      ram_addr_q <= mem_address;
    end
  end
  assign mem_readdata = ram[ram_addr_q];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h required=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Scoreboard monitor
  task automatic check_rsp(input logic port, input logic [31:0] data);
    logic [32:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL unexpected_rdv: port=%0d data=%h required=no response at %0t", port, data, $time);
    end else begin
      e = exp_q.pop_front();
      chk("rsp_port", 64'(port), 64'(e[32]));
      chk("rsp_data", 64'(data), 64'(e[31:0]));
    end
  endtask

  always @(negedge clk) begin
    if (m0_readdatavalid || m1_readdatavalid)
      chk("rdv_exclusive", 64'(m0_readdatavalid & m1_readdatavalid), 64'd0);
    if (m0_readdatavalid) check_rsp(1'b0, m0_readdata);
    if (m1_readdatavalid) check_rsp(1'b1, m1_readdata);
  end

  // Driver tasks
  task automatic rd(input logic port, input logic [13:0] addr, input logic [31:0] exp);
    @(negedge clk);
    if (port) begin m1_address = addr; m1_read = 1'b1; end
    else begin m0_address = addr; m0_read = 1'b1; end
    #1;
    chk(port ? "m1_rd_accept" : "m0_rd_accept",
        64'(port ? m1_waitrequest : m0_waitrequest), 64'd0);
    exp_q.push_back({port, exp});
    @(negedge clk);
    m0_read = 1'b0;
    m1_read = 1'b0;
  endtask

  task automatic wr(input logic port, input logic [13:0] addr, input logic [3:0] be,
                    input logic [31:0] data, input logic exp_mem_write);
    @(negedge clk);
    if (port) begin
      m1_address = addr; m1_byteenable = be; m1_writedata = data; m1_write = 1'b1;
    end else begin
      m0_address = addr; m0_byteenable = be; m0_writedata = data; m0_write = 1'b1;
    end
    #1;
    chk(port ? "m1_wr_accept" : "m0_wr_accept",
        64'(port ? m1_waitrequest : m0_waitrequest), 64'd0);
    chk("wr_mem_write", 64'(mem_write), 64'(exp_mem_write));
    chk("wr_chipselect", 64'(mem_chipselect), 64'd1);
    @(negedge clk);
    m0_write = 1'b0;
    m1_write = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  logic [19:0] burst_pat;
  logic [13:0] a0, a1;

  initial begin
    // Reset state, with m0 already requesting
    m0_read = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_m0_wait", 64'(m0_waitrequest), 64'd1);
    chk("rst_m1_wait", 64'(m1_waitrequest), 64'd1);
    chk("rst_rdv", 64'({m1_readdatavalid, m0_readdatavalid}), 64'd0);
    chk("rst_cs", 64'(mem_chipselect), 64'd0);
    chk("rst_mem_write", 64'(mem_write), 64'd0);
    chk("rst_clken", 64'(mem_clken), 64'd1);
    chk("rst_state", 64'(dbg_state), 64'(IDLE));
    m0_read = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    // 1: single m0 read
    rd(1'b0, 14'h0010, 32'hA500_0010);

    // 3: m1 partial write then m0 readback
    wr(1'b1, 14'h3FFF, 4'b0011, 32'hDEAD_BEEF, 1'b1);
    rd(1'b0, 14'h3FFF, 32'hA500_BEEF);
    rd(1'b1, 14'h3FFF, 32'hA500_BEEF);

    // 4: reset_req raised right after an accepted read
    @(negedge clk);
    m0_address = 14'h0020; m0_read = 1'b1;
    #1 chk("t4_accept", 64'(m0_waitrequest), 64'd0);
    exp_q.push_back({1'b0, 32'hA500_0020});
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      reset_req = 1'b1;
      m0_address = 14'h0021;
      m1_address = 14'h0030; m1_read = 1'b1;
      #1;
      chk("t4_waits", 64'({m1_waitrequest, m0_waitrequest}), 64'd3);
      chk("t4_cs", 64'(mem_chipselect), 64'd0);
      chk("t4_mem_reset_req", 64'(mem_reset_req), 64'd1);
    end
    @(negedge clk);
    reset_req = 1'b0; m1_read = 1'b0;
    #1 chk("t4_resume", 64'(m0_waitrequest), 64'd0);
    exp_q.push_back({1'b0, 32'hA500_0021});
    @(negedge clk);
    m0_read = 1'b0;

    // 5: async reset while a read response is pending
    @(negedge clk);
    m0_address = 14'h0040; m0_read = 1'b1;
    #1 chk("t5_accept", 64'(m0_waitrequest), 64'd0);
    @(posedge clk);
    #2;
    chk("t5_rdv_before_reset", 64'(m0_readdatavalid), 64'd1);
    reset = 1'b1;
    #1;
    chk("t5_rdv_dropped", 64'({m1_readdatavalid, m0_readdatavalid}), 64'd0);
    chk("t5_waits", 64'({m1_waitrequest, m0_waitrequest}), 64'd3);
    chk("t5_state", 64'(dbg_state), 64'(IDLE));
    @(negedge clk);
    m0_read = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    m0_address = 14'h0050; m1_address = 14'h0060; m0_read = 1'b1; m1_read = 1'b1;
    #1 chk("t5_first_tie", 64'({~m1_waitrequest, ~m0_waitrequest}), 64'b01);
    exp_q.push_back({1'b0, 32'hA500_0050});
    @(negedge clk);
    m0_read = 1'b0; m1_read = 1'b0;

    // 2: continuous contention from reset: 8 x m0, 8 x m1, then m0 again
    do_reset();
    burst_pat = 20'h0FF00;
    a0 = 14'h0100;
    a1 = 14'h0200;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      m0_address = a0; m1_address = a1; m0_read = 1'b1; m1_read = 1'b1;
      #1;
      chk("t2_grant", 64'({~m1_waitrequest, ~m0_waitrequest}),
          64'(burst_pat[c] ? 2'b10 : 2'b01));
      if (!m0_waitrequest) begin
        exp_q.push_back({1'b0, 32'hA500_0000 | 32'(a0)});
        a0 = a0 + 14'd1;
      end
      if (!m1_waitrequest) begin
        exp_q.push_back({1'b1, 32'hA500_0000 | 32'(a1)});
        a1 = a1 + 14'd1;
      end
    end
    @(negedge clk);
    m0_read = 1'b0; m1_read = 1'b0;

`ifdef CINERARIA_BOOTMEM_WPROT_EN
    // 6: protected m1 write is swallowed, m0 write goes through
    wprot = 1'b1;
    @(negedge clk);
    m1_address = 14'h0100; m1_byteenable = 4'hf; m1_writedata = 32'h1234_5678; m1_write = 1'b1;
    #1;
    chk("t6_m1_accept", 64'(m1_waitrequest), 64'd0);
    chk("t6_mem_write", 64'(mem_write), 64'd0);
    @(posedge clk);
    #1 chk("t6_wrerr_pulse", 64'(m1_wrerr), 64'd1);
    @(negedge clk);
    m1_write = 1'b0;
    @(posedge clk);
    #1 chk("t6_wrerr_clear", 64'(m1_wrerr), 64'd0);
    rd(1'b0, 14'h0100, 32'hA500_0100);
    wr(1'b0, 14'h0100, 4'hf, 32'h0BAD_F00D, 1'b1);
    rd(1'b0, 14'h0100, 32'h0BAD_F00D);
    wprot = 1'b0;
`endif

    repeat (4) @(negedge clk);
    #1 chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
